// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - fetch FSM encodings and instruction field positions
// Shared with the control unit decoder.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_t;

  localparam int OPC_HI = 15;
  localparam int RD_LO  = 11;
  localparam int RA_LO  = 8;
  localparam int IMM_HI = 7;

endpackage

// File: rtl/instr_fetch_pc_counter.sv
// rtl/instr_fetch_pc_counter.sv - program counter with load and wrapping increment
// Load has priority over increment so a branch taken on the ack edge is not lost.
module instr_fetch_pc_counter #(
  parameter int WADDR = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WADDR-1:0] i_target,
  input  logic             i_inc,
  output logic [WADDR-1:0] o_pc
);

  logic [WADDR-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, req/ack instruction read, IR and field decode
// Optional ack timeout with ERR state under INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int WADDR          = 8,
  parameter int WINSTR         = 16,
  parameter int WIMM           = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fetch_en,
  input  logic              i_pc_load,
  input  logic [WADDR-1:0]  i_pc_target,
  output logic              o_mem_req,
  output logic [WADDR-1:0]  o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [WINSTR-1:0] i_mem_rdata,
  output logic              o_instr_valid,
  input  logic              i_instr_consume,
  output logic [WINSTR-1:0] o_ir,
  output logic [1:0]        o_opcode,
  output logic [2:0]        o_rd,
  output logic [2:0]        o_ra,
  output logic [WIMM-1:0]   o_imm,
  output logic [WADDR-1:0]  o_pc,
  output logic              o_fetch_err
);

  import instr_fetch_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              w_ack_take;
  logic [WADDR-1:0]  w_pc;
  logic [WINSTR-1:0] r_ir;

  assign w_ack_take = (r_state == ST_REQ) && i_mem_ack;

  instr_fetch_pc_counter #(
    .WADDR (WADDR)
  ) u_pc_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (i_pc_load),
    .i_target (i_pc_target),
    .i_inc    (w_ack_take),
    .o_pc     (w_pc)
  );

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] r_wait_cnt;

  // Counts ack-less REQ cycles; held at zero outside REQ so each entry starts fresh.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != ST_REQ)) begin
      r_wait_cnt <= 4'd0;
    end else if (!i_mem_ack) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ack_take) begin
        r_ir <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_mem_req     = 1'b0;
    o_instr_valid = 1'b0;
    o_fetch_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_fetch_en) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_state_nxt = ST_HOLD;
`ifdef INSTR_FETCH_TIMEOUT_EN
        end else if (r_wait_cnt == CNT_LAST) begin
          w_state_nxt = ST_ERR;
`endif
        end
      end
      ST_HOLD: begin
        o_instr_valid = 1'b1;
        if (i_instr_consume) w_state_nxt = i_fetch_en ? ST_REQ : ST_IDLE;
      end
`ifdef INSTR_FETCH_TIMEOUT_EN
      ST_ERR: begin
        o_fetch_err = 1'b1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_mem_addr = w_pc;
  assign o_pc       = w_pc;
  assign o_ir       = r_ir;
  assign o_opcode   = r_ir[OPC_HI -: 2];
  assign o_rd       = r_ir[RD_LO +: 3];
  assign o_ra       = r_ir[RA_LO +: 3];
  assign o_imm      = r_ir[IMM_HI -: WIMM];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic        instr_consume;
  logic [15:0] ir;
  logic [1:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  ra;
  logic [7:0]  imm;
  logic [7:0]  pc;
  logic        fetch_err;

  instr_fetch dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fetch_en      (fetch_en),
    .i_pc_load       (pc_load),
    .i_pc_target     (pc_target),
    .o_mem_req       (mem_req),
    .o_mem_addr      (mem_addr),
    .i_mem_ack       (mem_ack),
    .i_mem_rdata     (mem_rdata),
    .o_instr_valid   (instr_valid),
    .i_instr_consume (instr_consume),
    .o_ir            (ir),
    .o_opcode        (opcode),
    .o_rd            (rd),
    .o_ra            (ra),
    .o_imm           (imm),
    .o_pc            (pc),
    .o_fetch_err     (fetch_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  int          mem_wait  = 0;
  int          req_cnt   = 0;
  logic        stray_ack = 1'b0;
  logic [7:0]  last_addr = 8'h00;

  // Memory answers after mem_wait ack-less REQ cycles; stray_ack forces a bogus ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
      end else if (mem_req) begin
        if (req_cnt == mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          last_addr = mem_addr;
        end else begin
          mem_ack = 1'b0;
        end
        req_cnt++;
      end else begin
        mem_ack = 1'b0;
        req_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_fetch(input int waits, output int lat, output int req_cycles, output logic moved);
    logic [7:0] first_addr;
    mem_wait   = waits;
    fetch_en   = 1'b1;
    step();
    fetch_en   = 1'b0;
    lat        = 1;
    req_cycles = 0;
    moved      = 1'b0;
    first_addr = mem_addr;
    while (!instr_valid && lat < 50) begin
      if (mem_req) begin
        req_cycles++;
        if (mem_addr !== first_addr) moved = 1'b1;
      end
      step();
      lat++;
    end
  endtask

  typedef struct {
    logic        do_load;
    logic [7:0]  target;
    logic [15:0] word;
    int          waits;
    logic [1:0]  e_opc;
    logic [2:0]  e_rd;
    logic [2:0]  e_ra;
    logic [7:0]  e_imm;
    logic [7:0]  e_addr;
    logic [7:0]  e_pc;
    int          e_lat;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat;
    int reqc;
    logic moved;

    vecs[0] = '{1'b0, 8'h00, 16'h4BFB, 0, 2'd1, 3'd1, 3'd3, 8'hFB, 8'h00, 8'h01, 2};
    vecs[1] = '{1'b0, 8'h00, 16'hC5A7, 3, 2'd3, 3'd0, 3'd5, 8'hA7, 8'h01, 8'h02, 5};
    vecs[2] = '{1'b1, 8'hFF, 16'h3F80, 1, 2'd0, 3'd7, 3'd7, 8'h80, 8'hFF, 8'h00, 3};
    vecs[3] = '{1'b1, 8'h10, 16'h9C01, 0, 2'd2, 3'd3, 3'd4, 8'h01, 8'h10, 8'h11, 2};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    rst           = 1'b1;
    fetch_en      = 1'b0;
    pc_load       = 1'b0;
    pc_target     = 8'h00;
    instr_consume = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_fields", {opcode, rd, ra, imm}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_load) begin
        pc_load   = 1'b1;
        pc_target = vecs[i].target;
        step();
        pc_load   = 1'b0;
      end
      mem[vecs[i].e_addr] = vecs[i].word;
      do_fetch(vecs[i].waits, lat, reqc, moved);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
      check($sformatf("v%0d_req_cycles", i), 32'(reqc), 32'(vecs[i].waits + 1));
      check($sformatf("v%0d_addr_stable", i), 32'(moved), 32'd0);
      check($sformatf("v%0d_addr", i), 32'(last_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_ir", i), 32'(ir), 32'(vecs[i].word));
      check($sformatf("v%0d_fields", i), {opcode, rd, ra, imm},
            {vecs[i].e_opc, vecs[i].e_rd, vecs[i].e_ra, vecs[i].e_imm});
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      instr_consume = 1'b1;
      step();
      instr_consume = 1'b0;
      check($sformatf("v%0d_consumed", i), {mem_req, instr_valid}, 32'd0);
    end

    // pc_load coincident with ack: IR captures, load beats increment.
    mem[8'h11] = 16'h1234;
    mem_wait   = 0;
    fetch_en   = 1'b1;
    step();
    fetch_en   = 1'b0;
    pc_load    = 1'b1;
    pc_target  = 8'h20;
    step();
    pc_load    = 1'b0;
    check("ldack_valid", 32'(instr_valid), 32'd1);
    check("ldack_ir", 32'(ir), 32'h1234);
    check("ldack_pc", 32'(pc), 32'h20);

    // Stall in HOLD with stray acks present.
    stray_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("hold%0d", k), {instr_valid, ir, pc}, {1'b1, 16'h1234, 8'h20});
    end
    stray_ack = 1'b0;

    mem[8'h20]    = 16'h0F0F;
    mem_wait      = 0;
    instr_consume = 1'b1;
    fetch_en      = 1'b1;
    step();
    instr_consume = 1'b0;
    fetch_en      = 1'b0;
    check("b2b_dead_cycle", {mem_req, instr_valid, mem_addr}, {1'b1, 1'b0, 8'h20});
    step();
    check("b2b_second", {instr_valid, ir, pc}, {1'b1, 16'h0F0F, 8'h21});
    instr_consume = 1'b1;
    step();
    instr_consume = 1'b0;

    stray_ack = 1'b1;
    step();
    step();
    step();
    stray_ack = 1'b0;
    check("idle_stray_ack", {instr_valid, mem_req, ir, pc}, {1'b0, 1'b0, 16'h0F0F, 8'h21});

    // Reset while waiting for ack, then a late ack.
    mem_wait = 1000;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    check("midrst_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_after", {mem_req, ir, pc}, 32'd0);
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    step();
    check("midrst_late_ack", {instr_valid, ir, pc}, 32'd0);

    // Memory that never answers.
    mem_wait = 1000;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int k = 0; k < 14; k++) step();
    check("to_req_cycle15", {mem_req, fetch_err}, {1'b1, 1'b0});
    step();
`ifdef INSTR_FETCH_TIMEOUT_EN
    check("to_err", {fetch_err, mem_req, pc}, {1'b1, 1'b0, 8'h00});
    fetch_en = 1'b1;
    step();
    step();
    step();
    fetch_en = 1'b0;
    check("to_err_sticky", {fetch_err, mem_req, instr_valid}, {1'b1, 1'b0, 1'b0});
`else
    check("to_no_timeout", {fetch_err, mem_req, pc}, {1'b0, 1'b1, 8'h00});
    for (int k = 0; k < 10; k++) step();
    check("to_still_waiting", {fetch_err, mem_req}, {1'b0, 1'b1});
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("to_reset_clears", {fetch_err, mem_req, instr_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
